tiny_soc_bram_arbiter: RTL

TINY_SOC_BRAM_ARBITER -- requirements
Module: tiny_soc_bram_arbiter

---
 rtl/tiny_soc_bram_arbiter.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/tiny_soc_bram_arbiter.sv
// ----------------------------------------------------------------------------
// tiny_soc_bram_arbiter
//
// Two-requester arbiter in front of a single-port BRAM with one-cycle read
// latency. Round-robin arbitration driven by a 1-bit last-grant register, with
// an optional per-requester lock that keeps the BRAM dedicated to one
// requester across consecutive accesses.
//
// Optional feature macro: TINY_SOC_BRAM_ARB_STATS_EN
//   When defined, adds free-running 32-bit grant and stall counters.
//
// Parameters
//   ADR_WIDTH : byte-address width of all address ports
//   DAT_WIDTH : data width (byte-enable width = DAT_WIDTH/8)
//
// Ports
//   clock, reset           : single rising-edge clock, synchronous active-high reset
//   mN_req/lock/adr/dat_w/sel/we : requester N (N=0,1) access request
//   mN_gnt                 : access accepted this cycle (combinational)
//   mN_dat_r, mN_rvalid    : read data, valid one cycle after the read grant
//   bram_adr/dat_w/sel/we  : BRAM access port, driven by the granted requester
//   bram_dat_r             : BRAM read data (one cycle after address)
//   m0_gnt_cnt, m1_gnt_cnt, stall_cnt : statistics (macro-enabled only)
// ----------------------------------------------------------------------------
module tiny_soc_bram_arbiter #(
    parameter int ADR_WIDTH = 32,
    parameter int DAT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,

    input  logic                   m0_req,
    input  logic                   m0_lock,
    input  logic [ADR_WIDTH-1:0]   m0_adr,
    input  logic [DAT_WIDTH-1:0]   m0_dat_w,
    input  logic [DAT_WIDTH/8-1:0] m0_sel,
    input  logic                   m0_we,
    output logic                   m0_gnt,
    output logic [DAT_WIDTH-1:0]   m0_dat_r,
    output logic                   m0_rvalid,

    input  logic                   m1_req,
    input  logic                   m1_lock,
    input  logic [ADR_WIDTH-1:0]   m1_adr,
    input  logic [DAT_WIDTH-1:0]   m1_dat_w,
    input  logic [DAT_WIDTH/8-1:0] m1_sel,
    input  logic                   m1_we,
    output logic                   m1_gnt,
    output logic [DAT_WIDTH-1:0]   m1_dat_r,
    output logic                   m1_rvalid,

    output logic [ADR_WIDTH-1:0]   bram_adr,
    output logic [DAT_WIDTH-1:0]   bram_dat_w,
    output logic [DAT_WIDTH/8-1:0] bram_sel,
    output logic                   bram_we,
    input  logic [DAT_WIDTH-1:0]   bram_dat_r
`ifdef TINY_SOC_BRAM_ARB_STATS_EN
    ,
    output logic [31:0]            m0_gnt_cnt,
    output logic [31:0]            m1_gnt_cnt,
    output logic [31:0]            stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_OPEN  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic                 last_gnt_r;     // 1 = requester 1 was granted last
    logic                 gnt0_s;
    logic                 gnt1_s;
    logic [1:0]           rd_pend_r;      // read accepted last cycle, per requester
    logic [DAT_WIDTH-1:0] held0_r;
    logic [DAT_WIDTH-1:0] held1_r;

    // State register: lock ownership, released by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_OPEN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: enter a lock on a locked grant, leave it on an
    // unlocked grant or when the owner drops req (lock abandoned).
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_OPEN: begin
                if (gnt0_s && m0_lock) begin
                    state_next_s = ST_LOCK0;
                end else if (gnt1_s && m1_lock) begin
                    state_next_s = ST_LOCK1;
                end else begin
                    state_next_s = ST_OPEN;
                end
            end
            ST_LOCK0: begin
                if (!m0_req || !m0_lock) begin
                    state_next_s = ST_OPEN;
                end else begin
                    state_next_s = ST_LOCK0;
                end
            end
            ST_LOCK1: begin
                if (!m1_req || !m1_lock) begin
                    state_next_s = ST_OPEN;
                end else begin
                    state_next_s = ST_LOCK1;
                end
            end
            default: begin
                state_next_s = ST_OPEN;
            end
        endcase
    end

    // Grant logic: the lock owner alone may be granted; otherwise a tie goes
    // to the requester that was not granted last.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (reset) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else begin
            case (state_r)
                ST_OPEN: begin
                    if (m0_req && m1_req) begin
                        gnt0_s = last_gnt_r;
                        gnt1_s = ~last_gnt_r;
                    end else begin
                        gnt0_s = m0_req;
                        gnt1_s = m1_req;
                    end
                end
                ST_LOCK0: begin
                    gnt0_s = m0_req;
                end
                ST_LOCK1: begin
                    gnt1_s = m1_req;
                end
                default: begin
                    gnt0_s = 1'b0;
                    gnt1_s = 1'b0;
                end
            endcase
        end
    end

    // Last-grant register: updated on every grant, locked or not.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_gnt_r <= 1'b1;
        end else if (gnt0_s) begin
            last_gnt_r <= 1'b0;
        end else if (gnt1_s) begin
            last_gnt_r <= 1'b1;
        end else begin
            last_gnt_r <= last_gnt_r;
        end
    end

    // Read tracking: a read granted now returns data on the next cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_pend_r <= 2'b00;
        end else begin
            rd_pend_r <= {gnt1_s & ~m1_we, gnt0_s & ~m0_we};
        end
    end

    // Read-data hold: keep the last returned word while rvalid is low.
    always_ff @(posedge clock) begin
        if (reset) begin
            held0_r <= '0;
            held1_r <= '0;
        end else begin
            if (rd_pend_r[0]) begin
                held0_r <= bram_dat_r;
            end else begin
                held0_r <= held0_r;
            end
            if (rd_pend_r[1]) begin
                held1_r <= bram_dat_r;
            end else begin
                held1_r <= held1_r;
            end
        end
    end

    // BRAM port mux: driven by the granted requester, all-zero when idle.
    always_comb begin
        bram_adr   = '0;
        bram_dat_w = '0;
        bram_sel   = '0;
        bram_we    = 1'b0;
        if (gnt0_s) begin
            bram_adr   = m0_adr;
            bram_dat_w = m0_dat_w;
            bram_sel   = m0_sel;
            bram_we    = m0_we;
        end else if (gnt1_s) begin
            bram_adr   = m1_adr;
            bram_dat_w = m1_dat_w;
            bram_sel   = m1_sel;
            bram_we    = m1_we;
        end else begin
            bram_adr   = '0;
            bram_dat_w = '0;
            bram_sel   = '0;
            bram_we    = 1'b0;
        end
    end

    assign m0_gnt = gnt0_s;
    assign m1_gnt = gnt1_s;

    // Reset gating hides a read that was accepted just before reset asserted.
    assign m0_rvalid = rd_pend_r[0] & ~reset;
    assign m1_rvalid = rd_pend_r[1] & ~reset;
    assign m0_dat_r  = reset ? '0 : (rd_pend_r[0] ? bram_dat_r : held0_r);
    assign m1_dat_r  = reset ? '0 : (rd_pend_r[1] ? bram_dat_r : held1_r);

`ifdef TINY_SOC_BRAM_ARB_STATS_EN
    logic stall_s;
    assign stall_s = (m0_req & ~gnt0_s) | (m1_req & ~gnt1_s);

    // Statistics counters: wrap naturally at 2^32.
    always_ff @(posedge clock) begin
        if (reset) begin
            m0_gnt_cnt <= 32'd0;
            m1_gnt_cnt <= 32'd0;
            stall_cnt  <= 32'd0;
        end else begin
            m0_gnt_cnt <= m0_gnt_cnt + {31'd0, gnt0_s};
            m1_gnt_cnt <= m1_gnt_cnt + {31'd0, gnt1_s};
            stall_cnt  <= stall_cnt + {31'd0, stall_s};
        end
    end
`endif

endmodule
